// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: MIPS opcode/funct encodings, forwarding select and
// the decoded-control bundle produced from an instruction word.
package decode_stage_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;

    typedef enum logic [1:0] {FWD_GPR, FWD_WB, FWD_MEM, FWD_EX} fwd_sel_t;
    typedef enum logic [1:0] {IMM_SEXT, IMM_ZEXT, IMM_LUI, IMM_LINK} imm_kind_t;
    typedef enum logic [1:0] {DST_NONE, DST_RD, DST_RT, DST_RA} dst_kind_t;

    typedef struct packed {
        logic      use_rs;
        logic      use_rt;
        dst_kind_t dst_kind;
        imm_kind_t imm_kind;
        logic      is_br;
        logic      br_ne;
        logic      is_j;
        logic      is_jr;
    } ctrl_t;

    // Anything not listed falls through as a nop (no sources, no destination).
    function automatic ctrl_t decode(input logic [31:0] instr);
        ctrl_t c;
        c = '0;
        case (instr[31:26])
            OP_SPECIAL: begin
                case (instr[5:0])
                    FN_ADDU, FN_SUBU: begin
                        c.use_rs = 1'b1; c.use_rt = 1'b1; c.dst_kind = DST_RD;
                    end
                    FN_JR: begin
                        c.use_rs = 1'b1; c.is_jr = 1'b1;
                    end
                    FN_JALR: begin
                        c.use_rs = 1'b1; c.is_jr = 1'b1;
                        c.dst_kind = DST_RD; c.imm_kind = IMM_LINK;
                    end
                    default: c = '0;
                endcase
            end
            OP_J:   c.is_j = 1'b1;
            OP_JAL: begin
                c.is_j = 1'b1; c.dst_kind = DST_RA; c.imm_kind = IMM_LINK;
            end
            OP_BEQ: begin
                c.use_rs = 1'b1; c.use_rt = 1'b1; c.is_br = 1'b1;
            end
            OP_BNE: begin
                c.use_rs = 1'b1; c.use_rt = 1'b1; c.is_br = 1'b1; c.br_ne = 1'b1;
            end
            OP_ORI: begin
                c.use_rs = 1'b1; c.dst_kind = DST_RT; c.imm_kind = IMM_ZEXT;
            end
            OP_LUI: begin
                c.dst_kind = DST_RT; c.imm_kind = IMM_LUI;
            end
            OP_LW: begin
                c.use_rs = 1'b1; c.dst_kind = DST_RT;
            end
            OP_SW: begin
                c.use_rs = 1'b1; c.use_rt = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_gprf.sv
// NREG x XLEN register file, two combinational read ports and one write port;
// register 0 is hardwired to zero and a same-cycle write is bypassed to readers.
module gprf #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int RW  = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0][RW-1:0]   raddr,
    output logic [1:0][XLEN-1:0] rdata,
    input  logic                 we,
    input  logic [RW-1:0]        waddr,
    input  logic [XLEN-1:0]      wdata
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            assign rdata[gi] = (raddr[gi] == '0)                ? '0    :
                               (we && waddr == raddr[gi])       ? wdata :
                                                                  regs[raddr[gi]];
        end
    endgenerate

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: decode, operand forwarding, hazard stalls, branch/jump
// resolution with one delay slot, and the ID/EX pipeline register.
import decode_stage_pkg::*;

module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int CNT_W = 32,
    localparam int RW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_valid,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [31:0]      if_instr,
    output logic             id_ready,
    input  logic             ex_wr_en,
    input  logic             ex_is_load,
    input  logic [RW-1:0]    ex_wr_addr,
    input  logic [XLEN-1:0]  ex_fwd_data,
    input  logic             mem_wr_en,
    input  logic             mem_is_load,
    input  logic [RW-1:0]    mem_wr_addr,
    input  logic [XLEN-1:0]  mem_fwd_data,
    input  logic             wb_en,
    input  logic [RW-1:0]    wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             ex_ready,
    input  logic             flush,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [31:0]      ex_instr,
    output logic [XLEN-1:0]  ex_rs_data,
    output logic [XLEN-1:0]  ex_rt_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [RW-1:0]    ex_dst,
    output logic             ex_dst_en,
    output logic             redirect,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] perf_stalls
);

    ctrl_t                 ctrl;
    logic [1:0][RW-1:0]    src_addr;
    logic [1:0][XLEN-1:0]  gpr_data;
    logic [XLEN-1:0]       src_data [2];
    logic [1:0]            src_used;
    logic [1:0]            load_use;
    logic [1:0]            br_haz;
    logic                  stall;
    logic                  issue;
    logic                  taken;
    logic [XLEN-1:0]       pc4;
    logic [XLEN-1:0]       imm_sext;
    logic [XLEN-1:0]       imm_val;
    logic [RW-1:0]         dst;

    assign ctrl        = decode(if_instr);
    assign src_addr[0] = if_instr[21 +: RW];
    assign src_addr[1] = if_instr[16 +: RW];
    assign src_used    = {ctrl.use_rt, ctrl.use_rs};

    gprf #(.XLEN(XLEN), .NREG(NREG)) u_gprf (
        .clk   (clk),
        .reset (reset),
        .raddr (src_addr),
        .rdata (gpr_data),
        .we    (wb_en),
        .waddr (wb_addr),
        .wdata (wb_data)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic            hit_ex, hit_mem, hit_wb;
            fwd_sel_t        sel;
            logic [XLEN-1:0] val;

            assign hit_ex  = ex_wr_en  && src_addr[gi] != '0 && ex_wr_addr  == src_addr[gi];
            assign hit_mem = mem_wr_en && src_addr[gi] != '0 && mem_wr_addr == src_addr[gi];
            assign hit_wb  = wb_en     && src_addr[gi] != '0 && wb_addr     == src_addr[gi];

            always_comb begin
                sel = FWD_GPR;
                if (hit_ex)       sel = FWD_EX;
                else if (hit_mem) sel = FWD_MEM;
                else if (hit_wb)  sel = FWD_WB;
            end

            always_comb begin
                val = gpr_data[gi];
                case (sel)
                    FWD_EX:  val = ex_fwd_data;
                    FWD_MEM: val = mem_fwd_data;
                    FWD_WB:  val = wb_data;
                    default: val = gpr_data[gi];
                endcase
            end

            assign src_data[gi] = val;
            assign load_use[gi] = src_used[gi] && hit_ex && ex_is_load;
            // Branches compare in ID, so any in-flight EX result or a MEM load is too late.
            assign br_haz[gi]   = src_used[gi] && (hit_ex || (hit_mem && mem_is_load));
        end
    endgenerate

    assign stall = if_valid && ((|load_use) || ((ctrl.is_br || ctrl.is_jr) && (|br_haz)));
    assign issue = if_valid && !stall && !flush;

    assign taken = ctrl.is_j || ctrl.is_jr ||
                   (ctrl.is_br && ((src_data[0] == src_data[1]) ^ ctrl.br_ne));

    // A flushed ID slot is consumed (killed), so IF may advance even if it would stall.
    assign id_ready = ex_ready && (flush || !stall);
    assign redirect = !reset && issue && ex_ready && taken;

    assign pc4      = if_pc + XLEN'(4);
    assign imm_sext = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};

    always_comb begin
        redirect_pc = pc4 + (imm_sext << 2);
        if (ctrl.is_jr)     redirect_pc = src_data[0];
        else if (ctrl.is_j) redirect_pc = {pc4[XLEN-1:28], if_instr[25:0], 2'b00};
    end

    always_comb begin
        imm_val = imm_sext;
        case (ctrl.imm_kind)
            IMM_ZEXT: imm_val = {{(XLEN-16){1'b0}}, if_instr[15:0]};
            IMM_LUI:  imm_val = {{(XLEN-16){1'b0}}, if_instr[15:0]} << 16;
            IMM_LINK: imm_val = pc4 + XLEN'(4);
            default:  imm_val = imm_sext;
        endcase
    end

    always_comb begin
        dst = '0;
        case (ctrl.dst_kind)
            DST_RD:  dst = if_instr[11 +: RW];
            DST_RT:  dst = if_instr[16 +: RW];
            DST_RA:  dst = {RW{1'b1}};
            default: dst = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_instr   <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_dst     <= '0;
            ex_dst_en  <= 1'b0;
        end else if (ex_ready) begin
            if (issue) begin
                ex_valid   <= 1'b1;
                ex_pc      <= if_pc;
                ex_instr   <= if_instr;
                ex_rs_data <= src_data[0];
                ex_rt_data <= src_data[1];
                ex_imm     <= imm_val;
                ex_dst     <= dst;
                ex_dst_en  <= ctrl.dst_kind != DST_NONE;
            end else begin
                ex_valid   <= 1'b0;
                ex_pc      <= '0;
                ex_instr   <= '0;
                ex_rs_data <= '0;
                ex_rt_data <= '0;
                ex_imm     <= '0;
                ex_dst     <= '0;
                ex_dst_en  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stalls <= '0;
        end else if (stall && ex_ready && !flush && perf_stalls != '1) begin
            perf_stalls <= perf_stalls + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: stimulus pushes expected ID/EX records into a
// queue, a negedge monitor pops and compares each issued instruction.
module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int CNT_W = 4;
    localparam int RW    = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             if_valid;
    logic [XLEN-1:0]  if_pc;
    logic [31:0]      if_instr;
    logic             id_ready;
    logic             ex_wr_en, ex_is_load;
    logic [RW-1:0]    ex_wr_addr;
    logic [XLEN-1:0]  ex_fwd_data;
    logic             mem_wr_en, mem_is_load;
    logic [RW-1:0]    mem_wr_addr;
    logic [XLEN-1:0]  mem_fwd_data;
    logic             wb_en;
    logic [RW-1:0]    wb_addr;
    logic [XLEN-1:0]  wb_data;
    logic             ex_ready, flush;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [31:0]      ex_instr;
    logic [XLEN-1:0]  ex_rs_data, ex_rt_data, ex_imm;
    logic [RW-1:0]    ex_dst;
    logic             ex_dst_en;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] perf_stalls;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .id_ready(id_ready),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_wr_addr(ex_wr_addr), .ex_fwd_data(ex_fwd_data),
        .mem_wr_en(mem_wr_en), .mem_is_load(mem_is_load), .mem_wr_addr(mem_wr_addr), .mem_fwd_data(mem_fwd_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_ready(ex_ready), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_instr(ex_instr),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_dst(ex_dst), .ex_dst_en(ex_dst_en),
        .redirect(redirect), .redirect_pc(redirect_pc), .perf_stalls(perf_stalls)
    );

    typedef struct {
        logic [31:0] pc, instr, rs, rt, imm;
        logic [4:0]  dst;
        logic        dst_en;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] idx);
        return {op, idx};
    endfunction

    task automatic push(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] imm, input int dst, input logic dst_en);
        exp_t e;
        e.pc = pc; e.instr = ins; e.rs = rs; e.rt = rt; e.imm = imm;
        e.dst = 5'(dst); e.dst_en = dst_en;
        exp_q.push_back(e);
    endtask

    task automatic clr();
        ex_wr_en = 0; ex_is_load = 0; ex_wr_addr = '0; ex_fwd_data = '0;
        mem_wr_en = 0; mem_is_load = 0; mem_wr_addr = '0; mem_fwd_data = '0;
        wb_en = 0; wb_addr = '0; wb_data = '0;
        ex_ready = 1; flush = 0;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] ins);
        if_valid = 1; if_pc = pc; if_instr = ins;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expected record per instruction captured into ID/EX.
    logic cap = 1'b0;
    always @(posedge clk) cap <= !reset && ex_ready;

    always @(negedge clk) begin : mon
        exp_t e;
        if (cap && !reset && ex_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got pc=%h required no issue", ex_pc);
            end else begin
                e = exp_q.pop_front();
                $display("issue pc=%h instr=%h rs=%h rt=%h imm=%h dst=%0d en=%0b",
                         ex_pc, ex_instr, ex_rs_data, ex_rt_data, ex_imm, ex_dst, ex_dst_en);
                chk("ex_pc", ex_pc, e.pc);
                chk("ex_instr", ex_instr, e.instr);
                chk("ex_rs_data", ex_rs_data, e.rs);
                chk("ex_rt_data", ex_rt_data, e.rt);
                chk("ex_imm", ex_imm, e.imm);
                chk("ex_dst", 32'(ex_dst), 32'(e.dst));
                chk("ex_dst_en", 32'(ex_dst_en), 32'(e.dst_en));
            end
        end
    end

    initial begin
        logic [31:0] ins;
        reset = 1; if_valid = 0; if_pc = '0; if_instr = '0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_pc", ex_pc, 32'd0);
        chk("rst_ex_imm", ex_imm, 32'd0);
        chk("rst_perf", 32'(perf_stalls), 32'd0);
        chk("rst_redirect", 32'(redirect), 32'd0);
        reset = 0;

        // WB write-through to a same-cycle read
        clr(); wb_en = 1; wb_addr = 5'd1; wb_data = 32'h5;
        ins = rtype(1, 1, 2, 6'h21); drive(32'h1000, ins);
        #1; chk("wb_bypass_id_ready", 32'(id_ready), 32'd1);
        push(32'h1000, ins, 32'h5, 32'h5, 32'h1021, 2, 1); tick();

        // immediate forms
        clr(); ins = itype(6'h0d, 0, 6, 16'h8001); drive(32'h1004, ins);
        push(32'h1004, ins, 0, 0, 32'h8001, 6, 1); tick();
        clr(); ins = itype(6'h0f, 0, 7, 16'h1234); drive(32'h1008, ins);
        push(32'h1008, ins, 0, 0, 32'h1234_0000, 7, 1); tick();
        clr(); ins = itype(6'h23, 1, 8, 16'hfffc); drive(32'h100c, ins);
        push(32'h100c, ins, 32'h5, 0, 32'hffff_fffc, 8, 1); tick();

        // forwarding priority EX > MEM > WB > GPR, and address 0 never matches
        clr(); ex_wr_en = 1; ex_wr_addr = 5'd1; ex_fwd_data = 32'haaaa;
        mem_wr_en = 1; mem_wr_addr = 5'd1; mem_fwd_data = 32'hbbbb;
        ins = rtype(1, 1, 9, 6'h21); drive(32'h1010, ins);
        push(32'h1010, ins, 32'haaaa, 32'haaaa, 32'h4821, 9, 1); tick();
        clr(); mem_wr_en = 1; mem_wr_addr = 5'd1; mem_fwd_data = 32'hbbbb;
        wb_en = 1; wb_addr = 5'd10; wb_data = 32'h77;
        ins = rtype(1, 10, 9, 6'h21); drive(32'h1014, ins);
        push(32'h1014, ins, 32'hbbbb, 32'h77, 32'h4821, 9, 1); tick();
        clr(); ex_wr_en = 1; ex_wr_addr = 5'd0; ex_fwd_data = 32'heeee;
        ins = rtype(0, 1, 11, 6'h21); drive(32'h1018, ins);
        push(32'h1018, ins, 0, 32'h5, 32'h5821, 11, 1); tick();

        // load-use: one bubble, then operand from MEM
        clr(); ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5'd3;
        ins = rtype(3, 0, 4, 6'h21); drive(32'h2000, ins);
        #1; chk("ldu_id_ready", 32'(id_ready), 32'd0);
        chk("ldu_perf_before", 32'(perf_stalls), 32'd0);
        tick();
        chk("ldu_bubble", 32'(ex_valid), 32'd0);
        chk("ldu_perf_after", 32'(perf_stalls), 32'd1);
        clr(); mem_wr_en = 1; mem_is_load = 1; mem_wr_addr = 5'd3; mem_fwd_data = 32'hdead_0001;
        #1; chk("ldu_resume_ready", 32'(id_ready), 32'd1);
        push(32'h2000, ins, 32'hdead_0001, 0, 32'h2021, 4, 1); tick();

        // taken beq with delay slot
        clr(); ins = itype(6'h04, 1, 1, 16'h0004); drive(32'h3000, ins);
        #1; chk("beq_redirect", 32'(redirect), 32'd1);
        chk("beq_target", redirect_pc, 32'h3014);
        push(32'h3000, ins, 32'h5, 32'h5, 32'h4, 0, 0); tick();
        clr(); ins = rtype(10, 1, 12, 6'h21); drive(32'h3004, ins);
        #1; chk("dslot_redirect", 32'(redirect), 32'd0);
        chk("dslot_id_ready", 32'(id_ready), 32'd1);
        push(32'h3004, ins, 32'h77, 32'h5, 32'h6021, 12, 1); tick();

        // jr after an ALU producer: one stall, then target from MEM
        clr(); ex_wr_en = 1; ex_wr_addr = 5'd5; ex_fwd_data = 32'h4000_0100;
        ins = rtype(5, 0, 0, 6'h08); drive(32'h4000, ins);
        #1; chk("jr_stall_ready", 32'(id_ready), 32'd0);
        chk("jr_stall_redirect", 32'(redirect), 32'd0);
        tick();
        clr(); mem_wr_en = 1; mem_wr_addr = 5'd5; mem_fwd_data = 32'h4000_0100;
        #1; chk("jr_redirect", 32'(redirect), 32'd1);
        chk("jr_target", redirect_pc, 32'h4000_0100);
        chk("jr_perf", 32'(perf_stalls), 32'd2);
        push(32'h4000, ins, 32'h4000_0100, 0, 32'h8, 0, 0); tick();

        // jalr / jal link values and j target; not-taken bne
        clr(); ins = rtype(1, 0, 13, 6'h09); drive(32'h5000, ins);
        #1; chk("jalr_target", redirect_pc, 32'h5);
        push(32'h5000, ins, 32'h5, 0, 32'h5008, 13, 1); tick();
        clr(); ins = jtype(6'h03, 26'h100); drive(32'h5008, ins);
        #1; chk("jal_redirect", 32'(redirect), 32'd1);
        chk("jal_target", redirect_pc, 32'h400);
        push(32'h5008, ins, 0, 0, 32'h5010, 31, 1); tick();
        clr(); ins = itype(6'h05, 1, 1, 16'h0002); drive(32'h5100, ins);
        #1; chk("bne_nt_redirect", 32'(redirect), 32'd0);
        push(32'h5100, ins, 32'h5, 32'h5, 32'h2, 0, 0); tick();

        // flush kills a taken bne
        clr(); flush = 1; ins = itype(6'h05, 1, 10, 16'hffff); drive(32'h6000, ins);
        #1; chk("flush_redirect", 32'(redirect), 32'd0);
        tick();
        chk("flush_bubble", 32'(ex_valid), 32'd0);

        // ex_ready=0 holds ID/EX and freezes the stall counter
        clr(); ins = rtype(1, 1, 2, 6'h21); drive(32'h7000, ins);
        push(32'h7000, ins, 32'h5, 32'h5, 32'h1021, 2, 1); tick();
        clr(); ex_ready = 0; ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5'd1;
        drive(32'h7004, ins);
        #1; chk("hold_id_ready", 32'(id_ready), 32'd0);
        tick();
        chk("hold_ex_pc", ex_pc, 32'h7000);
        chk("hold_ex_valid", 32'(ex_valid), 32'd1);
        chk("hold_perf", 32'(perf_stalls), 32'd2);
        clr(); push(32'h7004, ins, 32'h5, 32'h5, 32'h1021, 2, 1); tick();

        // saturation after 20 stalls, then reset mid-stall
        clr(); ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5'd3;
        drive(32'h7100, rtype(3, 0, 4, 6'h21));
        repeat (20) tick();
        chk("perf_saturate", 32'(perf_stalls), 32'hf);
        reset = 1; clr(); drive(32'h7200, jtype(6'h02, 26'h40));
        #1;
        chk("midrst_perf", 32'(perf_stalls), 32'd0);
        chk("midrst_ex_valid", 32'(ex_valid), 32'd0);
        chk("midrst_redirect", 32'(redirect), 32'd0);
        tick();
        reset = 0;
        clr(); ins = rtype(1, 10, 2, 6'h21); drive(32'h8000, ins);
        push(32'h8000, ins, 0, 0, 32'h1021, 2, 1); tick();
        if_valid = 0;
        repeat (3) tick();
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
